// File: rtl/piso_pkg.sv
// Shared types and helpers for the serial transmit / capture chain.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Width of a counter that spans 0 .. width-1.
   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down counter with enable and zero flag; stops at zero instead of wrapping.
module bit_down_counter #(
   parameter int W = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clock) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (en && (count != '0))
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per enabled clock.
module piso_shift_tx
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);

   localparam int CW = cnt_w(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic             sout_nxt, sout_valid_nxt, done_nxt;
   logic [CW-1:0]    bitcnt;
   logic             cnt_zero;
   logic             accept, advance;

   bit_down_counter #(.W(CW)) u_cnt (
      .clock      (clock),
      .reset      (reset),
      .load       (accept),
      .load_value (CW'(WIDTH - 1)),
      .en         (advance),
      .count      (bitcnt),
      .zero       (cnt_zero)
   );

   // Ready while idle, or on the enabled last-bit cycle so a new word follows with no gap.
   assign load_ready = (state == IDLE) || (shift_en && cnt_zero);
   assign accept     = load_valid && load_ready;
   assign advance    = (state == SHIFT) && shift_en && !cnt_zero;

   always_comb begin
      state_nxt      = state;
      shreg_nxt      = shreg;
      sout_nxt       = sout;
      sout_valid_nxt = sout_valid;
      done_nxt       = done;
      if (accept) begin
         state_nxt      = SHIFT;
         shreg_nxt      = load_data;
         sout_nxt       = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
         sout_valid_nxt = 1'b1;
         done_nxt       = 1'b0;
      end else if ((state == SHIFT) && shift_en) begin
         if (!cnt_zero) begin
            if (MSB_FIRST) begin
               shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
               sout_nxt  = shreg[WIDTH-2];
            end else begin
               shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
               sout_nxt  = shreg[1];
            end
            done_nxt = (bitcnt == CW'(1));
         end else begin
            state_nxt      = IDLE;
            sout_nxt       = 1'b0;
            sout_valid_nxt = 1'b0;
            done_nxt       = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         shreg      <= shreg_nxt;
         sout       <= sout_nxt;
         sout_valid <= sout_valid_nxt;
         done       <= done_nxt;
      end
   end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: one MSB-first and one LSB-first instance share stimulus.
module tb_piso_shift_tx;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       load_valid = 1'b0;
   logic       shift_en = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic       rdy_m, sout_m, sv_m, done_m;
   logic       rdy_l, sout_l, sv_l, done_l;
   logic [3:0] obs, exp;
   int         checks = 0;
   int         errors = 0;

   always #5 clock = ~clock;

   piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clock(clock), .reset(reset), .load_data(load_data), .load_valid(load_valid),
      .load_ready(rdy_m), .shift_en(shift_en), .sout(sout_m), .sout_valid(sv_m), .done(done_m)
   );

   piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clock(clock), .reset(reset), .load_data(load_data), .load_valid(load_valid),
      .load_ready(rdy_l), .shift_en(shift_en), .sout(sout_l), .sout_valid(sv_l), .done(done_l)
   );

   // Each cycle: inputs change 1 after the edge, outputs are compared 1 later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // obs/exp fields are {sout, sout_valid, done, load_ready}
   task automatic test_reset();
      reset = 1'b1; load_valid = 1'b0; shift_en = 1'b0; load_data = 8'h00;
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         obs = {sout_m, sv_m, done_m, rdy_m};
         exp = 4'b0001;
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: got %b want %b", i, obs, exp);
         end
         tick();
      end
   endtask

   task automatic test_single();
      bit bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      load_data = 8'hA5; load_valid = 1'b1; shift_en = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         obs = {sout_m, sv_m, done_m, rdy_m};
         exp = {bits[i], 1'b1, (i == 7), (i == 7)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL single_a5 bit%0d: got %b want %b", i, obs, exp);
         end
         tick();
      end
      #1;
      obs = {sout_m, sv_m, done_m, rdy_m};
      checks++;
      if (obs !== 4'b0001) begin
         errors++;
         $display("FAIL single_idle: got %b want 0001", obs);
      end
   endtask

   // LSB-first 0x81 with a 3-cycle stall after bit 1 and a 1-cycle stall on the last bit.
   task automatic test_stall();
      bit s  [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      bit en [12] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 1};
      bit d  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      bit r  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      load_data = 8'h81; load_valid = 1'b1; shift_en = 1'b0;
      #1;
      checks++;
      if (rdy_l !== 1'b1) begin
         errors++;
         $display("FAIL stall_idle_ready: got %b want 1", rdy_l);
      end
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         shift_en = en[i];
         #1;
         obs = {sout_l, sv_l, done_l, rdy_l};
         exp = {s[i], 1'b1, d[i], r[i]};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL stall_81 cyc%0d: got %b want %b", i, obs, exp);
         end
         tick();
      end
      shift_en = 1'b1;
      #1;
      obs = {sout_l, sv_l, done_l, rdy_l};
      checks++;
      if (obs !== 4'b0001) begin
         errors++;
         $display("FAIL stall_idle: got %b want 0001", obs);
      end
   endtask

   task automatic test_back_to_back();
      load_data = 8'hFF; load_valid = 1'b1; shift_en = 1'b1;
      tick();
      load_data = 8'h00;
      for (int i = 0; i < 16; i++) begin
         #1;
         obs = {sout_m, sv_m, done_m, rdy_m};
         exp = {(i < 8), 1'b1, (i == 7 || i == 15), (i == 7 || i == 15)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL b2b bit%0d: got %b want %b", i, obs, exp);
         end
         tick();
         if (i == 7) load_valid = 1'b0;
      end
      #1;
      obs = {sout_m, sv_m, done_m, rdy_m};
      checks++;
      if (obs !== 4'b0001) begin
         errors++;
         $display("FAIL b2b_idle: got %b want 0001", obs);
      end
   endtask

   task automatic test_mid_reset();
      bit bits [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
      load_data = 8'hF0; load_valid = 1'b1; shift_en = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         obs = {sout_m, sv_m, done_m, rdy_m};
         checks++;
         if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL midrst_f0 bit%0d: got %b want 1100", i, obs);
         end
         if (i == 3) reset = 1'b1;
         tick();
      end
      reset = 1'b0;
      #1;
      obs = {sout_m, sv_m, done_m, rdy_m};
      checks++;
      if (obs !== 4'b0001) begin
         errors++;
         $display("FAIL midrst_abort: got %b want 0001", obs);
      end
      load_data = 8'h0F; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         obs = {sout_m, sv_m, done_m, rdy_m};
         exp = {bits[i], 1'b1, (i == 7), (i == 7)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL midrst_0f bit%0d: got %b want %b", i, obs, exp);
         end
         tick();
      end
   endtask

   // load_data toggles and load_valid stays high while ready is low; neither may disturb 0x3C.
   task automatic test_ignored_data();
      bit bits [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
      load_data = 8'h3C; load_valid = 1'b1; shift_en = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         load_data = ~load_data;
         load_valid = (i != 7);
         #1;
         obs = {sout_m, sv_m, done_m, rdy_m};
         exp = {bits[i], 1'b1, (i == 7), (i == 7)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL ignored_m bit%0d: got %b want %b", i, obs, exp);
         end
         obs = {sout_l, sv_l, done_l, rdy_l};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL ignored_l bit%0d: got %b want %b", i, obs, exp);
         end
         tick();
      end
      #1;
      obs = {sout_m, sv_m, done_m, rdy_m};
      checks++;
      if (obs !== 4'b0001) begin
         errors++;
         $display("FAIL ignored_idle: got %b want 0001", obs);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_back_to_back();
      test_mid_reset();
      test_ignored_data();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in, serial-out shift transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per enabled clock on a single serial line. A downstream chain of D flip-flops samples that line on the same rising edge. It is the sending end that feeds the flip-flop/counter capture chain and supplies the bit stream that chain registers.

## Interface
Parameters:
- WIDTH, default 8: word length in bits. Legal range 2..32.
- MSB_FIRST, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- clock, input, 1: the single clock. All state changes on its posedge.
- reset, input, 1: synchronous, active-high reset, sampled on posedge clock.
- load_data, input, WIDTH: word to transmit.
- load_valid, input, 1: load_data is valid.
- load_ready, output, 1: the transmitter can accept a word this cycle (combinational).
- shift_en, input, 1: advance enable. When low, the serial line and the shift state hold.
- sout, output, 1: serial data, registered.
- sout_valid, output, 1: sout carries a payload bit, registered.
- done, output, 1: one-cycle pulse concurrent with the last bit of a word, registered.

## Operation
- States: IDLE, SHIFT.
- Reset forces IDLE, shreg=0, bitcnt=0, sout=0, sout_valid=0, done=0. load_ready=1 in the first cycle after reset.
- Accept: a handshake is load_valid && load_ready at a posedge.
- IDLE:
  - load_ready=1.
  - On accept: load shreg with load_data, set bitcnt=WIDTH-1, drive sout with the first bit, set sout_valid=1, move to SHIFT.
  - The load does not depend on shift_en.
- SHIFT with shift_en=1 and bitcnt>0:
  - Shift shreg by one position (left if MSB_FIRST, else right), zero-filling.
  - sout takes the next bit.
  - bitcnt decrements.
  - done=1 when the new bitcnt is 0.
- SHIFT with shift_en=1 and bitcnt==0 (last bit being presented):
  - load_ready=1.
  - If a load is accepted in the same cycle: reload exactly as in IDLE and stay in SHIFT. This is back-to-back with no gap bit.
  - Otherwise go to IDLE with sout_valid=0 and sout=0.
  - done clears.
- SHIFT with shift_en=0: load_ready=0, all registers hold, done holds its value.
  - done is therefore high for exactly one enabled cycle.
- Counter width is $clog2(WIDTH). bitcnt never wraps below 0 and never exceeds WIDTH-1.
- Reset asserted mid-word aborts the word immediately.
  - No done pulse.
  - The partial word is discarded.
  - The next cycle is IDLE.
- load_data is sampled only on an accepted edge. Changes at other times are ignored.

## Timing
- Word accepted at edge k:
  - The first bit is valid on sout from after edge k until the next enabled edge.
  - With shift_en held at 1, bits occupy cycles k+1 .. k+WIDTH.
  - done=1 in cycle k+WIDTH.
  - sout_valid drops after edge k+WIDTH unless a reload occurred.
- Throughput: one word per WIDTH enabled cycles in back-to-back mode.
- Latency: load to first bit is 1 cycle. Load to done is WIDTH cycles plus the number of stalled cycles.
- load_ready is combinational from state, bitcnt and shift_en. No other output is combinational.

## Structure
- Shared package piso_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - the function cnt_w(WIDTH) returning $clog2(WIDTH).
- One sub-module: bit_down_counter. It is a loadable down counter with enable and a zero flag, parameterised by width, and reusable by the counter projects.
- The shift register and FSM stay in the top module.

## Test plan
- Reset then idle: assert reset for 2 cycles, then release. Required: sout=0, sout_valid=0, done=0, load_ready=1 and stable for 10 cycles.
- Single word, WIDTH=8, MSB_FIRST=1: load 0xA5 with shift_en=1.
  - sout sequence over cycles 1..8 is 1,0,1,0,0,1,0,1 with sout_valid=1 throughout.
  - done=1 only in cycle 8; IDLE in cycle 9.
- Stall: load 0x81 (MSB_FIRST=0) and drop shift_en for 3 cycles after the 2nd bit.
  - The 2nd bit (0) holds for 4 cycles and load_ready=0 during the stall.
  - The sequence is 1,0,0,0,0,0,0,1 and done rises once.
- Back-to-back: hold load_valid with 0xFF then 0x00.
  - load_ready=1 exactly in the last-bit cycle.
  - Result is 16 contiguous valid bits (eight 1s, then eight 0s) with two done pulses 8 cycles apart.
- Mid-word reset: load 0xF0 and assert reset at bit 4.
  - The next cycle shows sout_valid=0 and no done pulse.
  - A subsequent load of 0x0F transmits correctly.
- Ignored data: toggle load_data every cycle during a transmission. The serial output still matches the word captured at the accept edge.
